// File: rtl/comp_search_ctrl.sv
// comp_search_ctrl: successive-approximation search driving an external
// less/equal/greater comparator, MSB to LSB, at most WIDTH queries.
module comp_search_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] guess,
    output logic             q_valid,
    input  logic             l,
    input  logic             e,
    input  logic             g,
    input  logic             r_valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] QUERY = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [WIDTH-1:0] TOP = WIDTH'(1) << (WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] upd;
    logic             legal;

    // mask is the one-hot bit currently under test
    always_comb begin
        legal = (l ^ e ^ g) & ~(l & e & g);
        upd   = l ? guess : guess & ~mask;
    end

    assign q_valid = state == QUERY;
    assign busy    = state != IDLE;
    assign done    = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            guess  <= '0;
            mask   <= '0;
            result <= '0;
            found  <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    result <= '0;
                    found  <= 1'b0;
                    err    <= 1'b0;
                    guess  <= TOP;
                    mask   <= TOP;
                    state  <= QUERY;
                end
                QUERY: if (r_valid) begin
                    if (!legal) begin
                        err    <= 1'b1;
                        result <= guess;
                        state  <= DONE;
                    end else if (e) begin
                        result <= guess;
                        found  <= 1'b1;
                        state  <= DONE;
                    end else if (mask[0]) begin
                        result <= upd;
                        found  <= 1'b1;
                        state  <= DONE;
                    end else begin
                        guess <= upd | (mask >> 1);
                        mask  <= mask >> 1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/comp_search_ctrl.md
COMP_SEARCH_CTRL -- requirements
Module: comp_search_ctrl

Interface
REQ-001 Parameter: WIDTH, 4, bit width of guess/result (WIDTH >= 2).
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request a new search; sampled only in IDLE.
REQ-006 guess  output  WIDTH  query value presented to external comparator (a=guess, b=hidden target).
REQ-007 q_valid  output  1  guess valid, awaiting response.
REQ-008 l  input  1  comparator: guess < target.
REQ-009 e  input  1  comparator: guess == target.
REQ-010 g  input  1  comparator: guess > target.
REQ-011 r_valid  input  1  l/e/g valid; may be tied to q_valid for a combinational comparator.
REQ-012 busy  output  1  high in QUERY and DONE.
REQ-013 done  output  1  single-cycle completion pulse.
REQ-014 result  output  WIDTH  final search value.
REQ-015 found  output  1  result valid, search ended without error.
REQ-016 err  output  1  search aborted on illegal response.

Function
REQ-017 States SHALL be IDLE, QUERY, DONE; successive-approximation search MSB to LSB, at most WIDTH queries.
REQ-018 IDLE: start=1 at edge N SHALL clear result/found/err, load guess = 1<<(WIDTH-1), bit index = WIDTH-1, enter QUERY; q_valid=1 from cycle N+1.
REQ-019 QUERY: q_valid SHALL be 1; guess SHALL stay stable until a response is accepted (q_valid && r_valid at an edge).
REQ-020 Response legal only if exactly one of l, e, g is 1; any other combination SHALL set err=1, found=0, result=current guess, enter DONE.
REQ-021 Legal e=1: result=guess, found=1, enter DONE (early exit).
REQ-022 Legal l=1: keep current bit; g=1: clear current bit.
REQ-023 After l/g on bit index 0: result=updated value, found=1, enter DONE.
REQ-024 Otherwise: decrement bit index, set next lower bit in guess, stay in QUERY with q_valid held high (one query per cycle when r_valid tied to q_valid).
REQ-025 DONE lasts exactly one cycle with done=1, q_valid=0, then IDLE.
REQ-026 result/found/err SHALL hold after DONE until the next accepted start.
REQ-027 start in QUERY or DONE SHALL be ignored (not queued).
REQ-028 r_valid while q_valid=0 SHALL be ignored.
REQ-029 guess SHALL never exceed 2^WIDTH-1; no arithmetic wrap; bit operations only.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE and guess=0, q_valid=0, busy=0, done=0, result=0, found=0, err=0, regardless of clock.
REQ-031 Reset mid-search SHALL abandon the search with no done pulse; first start after rst_n rises begins a fresh search.

Verification (WIDTH=4, r_valid=q_valid, ideal comparator unless stated)
REQ-032 Target 10, start at edge N -> guesses 8(l), 12(g), 10(e) in cycles N+1..N+3; done=1 in N+4; result=10, found=1, err=0.
REQ-033 Target 0 -> guesses 8, 4, 2, 1 all g; done after 4 queries; result=0, found=1.
REQ-034 Target 15 -> guesses 8, 12, 14 (l), 15 (e); result=15, found=1.
REQ-035 First response l=1, g=1 -> err=1, found=0, result=8, done pulse next cycle.
REQ-036 r_valid delayed 3 cycles per query, start pulsed while busy -> guess/q_valid stable while waiting, extra start ignored, correct result for target 5 (8 g, 4 l, 6 g, 5 e).
REQ-037 rst_n low during second query of target 10 -> all outputs 0 asynchronously, no done; new start afterwards completes REQ-032 sequence.
